// File: rtl/window3x3_stream.sv
// Raster-stream 3x3 window generator: two line memories plus column shifters, one registered window per interior pixel.
// Optional WIN3_SOF_SYNC_EN adds a sof input that re-anchors the position counters to (0,0).
module window3x3_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pixel_in,
`ifdef WIN3_SOF_SYNC_EN
  input  logic              sof,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pixel_00,
  output logic [DATA_W-1:0] pixel_01,
  output logic [DATA_W-1:0] pixel_02,
  output logic [DATA_W-1:0] pixel_10,
  output logic [DATA_W-1:0] pixel_11,
  output logic [DATA_W-1:0] pixel_12,
  output logic [DATA_W-1:0] pixel_20,
  output logic [DATA_W-1:0] pixel_21,
  output logic [DATA_W-1:0] pixel_22,
  output logic [XW-1:0]     center_x,
  output logic [YW-1:0]     center_y,
  output logic              out_last
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          sof_hit;
  logic          accept;
  logic          emit;
  logic          x_end;
  logic          y_end;

  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] lb2_rd;

  // Index 0 is the oldest column, index 2 the most recently loaded one.
  logic [DATA_W-1:0] top [3];
  logic [DATA_W-1:0] mid [3];
  logic [DATA_W-1:0] bot [3];

`ifdef WIN3_SOF_SYNC_EN
  assign sof_hit = sof;
`else
  assign sof_hit = 1'b0;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A sof pixel is treated as if it sat at (0,0), regardless of the counters.
  assign px    = sof_hit ? '0 : x;
  assign py    = sof_hit ? '0 : y;
  assign x_end = (px == XW'(IMG_W - 1));
  assign y_end = (py == YW'(IMG_H - 1));
  assign emit  = (px >= XW'(2)) && (py >= YW'(2));

  assign lb1_rd = lb1[px];
  assign lb2_rd = lb2[px];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : py + YW'(1);
      end else begin
        x <= px + XW'(1);
        y <= py;
      end
    end
  end

  // Line memories carry no reset: rows 0 and 1 of a frame never reach the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[px] <= pixel_in;
      lb2[px] <= lb1_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        top[i] <= '0;
        mid[i] <= '0;
        bot[i] <= '0;
      end
    end else if (accept) begin
      top[0] <= top[1];
      top[1] <= top[2];
      top[2] <= lb2_rd;
      mid[0] <= mid[1];
      mid[1] <= mid[2];
      mid[2] <= lb1_rd;
      bot[0] <= bot[1];
      bot[1] <= bot[2];
      bot[2] <= pixel_in;
    end
  end

  // Output stage loads the post-shift window directly from the pre-shift columns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      pixel_00  <= '0;
      pixel_01  <= '0;
      pixel_02  <= '0;
      pixel_10  <= '0;
      pixel_11  <= '0;
      pixel_12  <= '0;
      pixel_20  <= '0;
      pixel_21  <= '0;
      pixel_22  <= '0;
      center_x  <= '0;
      center_y  <= '0;
      out_last  <= 1'b0;
    end else if (accept && emit) begin
      out_valid <= 1'b1;
      pixel_00  <= top[1];
      pixel_01  <= top[2];
      pixel_02  <= lb2_rd;
      pixel_10  <= mid[1];
      pixel_11  <= mid[2];
      pixel_12  <= lb1_rd;
      pixel_20  <= bot[1];
      pixel_21  <= bot[2];
      pixel_22  <= pixel_in;
      center_x  <= px - XW'(1);
      center_y  <= py - YW'(1);
      out_last  <= x_end && y_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
